// File: rtl/rev_counter_disp_pkg.sv
// Shared 7-segment glyphs (active-low, bit 0 = a .. bit 6 = g), blank pattern and digit-select polarity.
// Also holds the BCD nibble clamp used on load and on each count step.
package rev_counter_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic AN_ON  = 1'b0;
    localparam logic AN_OFF = 1'b1;

    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
// Latency: 0 cycles; no flow control.
module hex7seg_dec (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    import rev_counter_disp_pkg::*;

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/rev_counter_disp.sv
// Binary/BCD up-down counter with load, enable and a multiplexed 7-seg driver with leading-zero blanking.
// Latency: cnt/Rc 1 cycle after the tick or load cycle, display 1 cycle behind cnt; free-running, no backpressure.
module rev_counter_disp #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  bcd,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  Rc,
    output logic [6:0]            segment,
    output logic [DIGITS-1:0]     AN
);
    import rev_counter_disp_pkg::*;

    localparam int W  = 4 * DIGITS;
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] AN_DIG0 = ~(DIGITS'(1));

    logic [TW-1:0]     r_tick_cnt;
    logic [SW-1:0]     r_scan_cnt;
    logic [DW-1:0]     r_dig;
    logic [W-1:0]      r_cnt;
    logic              r_rc;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;

    logic              w_tick;
    logic              w_scan_wrap;
    logic [W-1:0]      w_step_val;
    logic [W-1:0]      w_load_sat;
    logic              w_wrap;
    logic              w_ripple;
    logic [3:0]        w_nib_sat;
    logic [DIGITS-1:0] w_lz;
    logic              w_zero_above;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [DIGITS-1:0] w_an;
    logic [6:0]        w_seg;

    assign w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_scan_wrap = (r_scan_cnt == SW'(SCAN_DIV - 1));

    // Next count value; in BCD mode out-of-range nibbles are clamped to 9 before rippling.
    always_comb begin
        w_step_val = r_cnt;
        w_load_sat = load_val;
        w_wrap     = 1'b0;
        w_ripple   = 1'b1;
        w_nib_sat  = 4'd0;
        if (bcd) begin
            for (int i = 0; i < DIGITS; i++) begin
                w_nib_sat = bcd_sat(r_cnt[4*i +: 4]);
                w_load_sat[4*i +: 4] = bcd_sat(load_val[4*i +: 4]);
                if (!w_ripple) begin
                    w_step_val[4*i +: 4] = w_nib_sat;
                end else if (dir) begin
                    if (w_nib_sat == 4'd9) begin
                        w_step_val[4*i +: 4] = 4'd0;
                    end else begin
                        w_step_val[4*i +: 4] = w_nib_sat + 4'd1;
                        w_ripple = 1'b0;
                    end
                end else begin
                    if (w_nib_sat == 4'd0) begin
                        w_step_val[4*i +: 4] = 4'd9;
                    end else begin
                        w_step_val[4*i +: 4] = w_nib_sat - 4'd1;
                        w_ripple = 1'b0;
                    end
                end
            end
            w_wrap = w_ripple;
        end else begin
            w_step_val = dir ? (r_cnt + W'(1)) : (r_cnt - W'(1));
            w_wrap     = dir ? (&r_cnt) : (r_cnt == '0);
        end
    end

    // w_lz[i] is set when nibbles i..DIGITS-1 are all zero.
    always_comb begin
        w_lz         = '0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above & (r_cnt[4*i +: 4] == 4'd0);
            w_lz[i]      = w_zero_above;
        end
    end

    always_comb begin
        w_nib   = 4'd0;
        w_blank = 1'b0;
        w_an    = {DIGITS{AN_OFF}};
        for (int i = 0; i < DIGITS; i++) begin
            if (r_dig == DW'(i)) begin
                w_nib   = r_cnt[4*i +: 4];
                w_blank = blank_lz && (i != 0) && w_lz[i];
                w_an[i] = AN_ON;
            end
        end
        if (w_blank) begin
            w_an = {DIGITS{AN_OFF}};
        end
    end

    hex7seg_dec u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_scan_cnt <= '0;
            r_dig      <= '0;
            r_cnt      <= '0;
            r_rc       <= 1'b0;
            r_an       <= AN_DIG0;
            r_seg      <= SEG_0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_rc       <= 1'b0;
            if (load) begin
                r_cnt <= bcd ? w_load_sat : load_val;
            end else if (w_tick && en) begin
                r_cnt <= w_step_val;
                r_rc  <= w_wrap;
            end
            if (w_scan_wrap) begin
                r_scan_cnt <= '0;
                r_dig      <= (r_dig == DW'(DIGITS - 1)) ? '0 : r_dig + DW'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + SW'(1);
            end
            r_an  <= w_an;
            r_seg <= w_blank ? SEG_BLANK : w_seg;
        end
    end

    assign cnt     = r_cnt;
    assign Rc      = r_rc;
    assign AN      = r_an;
    assign segment = r_seg;

endmodule

// File: tb/tb_rev_counter_disp.sv
// Bench for rev_counter_disp: arithmetic reference model compared every cycle, plus directed literal checks.
module tb_rev_counter_disp;
    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        dir = 1'b1;
    logic        bcd = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [15:0] cnt;
    logic        Rc;
    logic [6:0]  segment;
    logic [3:0]  AN;

    int checks = 0;
    int failures = 0;

    logic [6:0] GLYPH [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 clk = ~clk;

    rev_counter_disp #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .bcd      (bcd),
        .load     (load),
        .load_val (load_val),
        .blank_lz (blank_lz),
        .cnt      (cnt),
        .Rc       (Rc),
        .segment  (segment),
        .AN       (AN)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decimal view of a BCD word, each digit clamped to 9.
    function automatic int bcd2int(input logic [15:0] v);
        int n;
        logic [3:0] d;
        n = 0;
        for (int i = 3; i >= 0; i--) begin
            d = v[4*i +: 4];
            if (d > 4'd9) d = 4'd9;
            n = n * 10 + int'(d);
        end
        return n;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] v;
        int m;
        m = n;
        v = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            v[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return v;
    endfunction

    function automatic logic [15:0] step_val(input logic [15:0] v, input logic up, input logic b);
        int n;
        if (!b) return up ? v + 16'd1 : v - 16'd1;
        n = bcd2int(v);
        if (up) n = (n == 9999) ? 0 : n + 1;
        else    n = (n == 0) ? 9999 : n - 1;
        return int2bcd(n);
    endfunction

    function automatic logic step_wrap(input logic [15:0] v, input logic up, input logic b);
        if (!b) return up ? (v == 16'hFFFF) : (v == 16'h0000);
        return up ? (bcd2int(v) == 9999) : (bcd2int(v) == 0);
    endfunction

    function automatic logic is_blank(input int d, input logic [15:0] v, input logic blz);
        logic [15:0] sh;
        sh = v >> (4 * d);
        return blz && (d > 0) && (sh == 16'h0000);
    endfunction

    function automatic logic [3:0] exp_an(input int d, input logic [15:0] v, input logic blz);
        logic [3:0] one;
        one = 4'b0001;
        if (is_blank(d, v, blz)) return 4'b1111;
        return ~(one << d);
    endfunction

    function automatic logic [6:0] exp_seg(input int d, input logic [15:0] v, input logic blz);
        logic [15:0] sh;
        sh = v >> (4 * d);
        if (is_blank(d, v, blz)) return 7'b1111111;
        return GLYPH[sh[3:0]];
    endfunction

    int          m_tick = 0;
    int          m_scan = 0;
    int          m_dig = 0;
    logic [15:0] m_cnt = 16'h0000;
    logic        m_rc = 1'b0;
    logic [3:0]  m_an = 4'b1110;
    logic [6:0]  m_seg = 7'b1000000;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_tick  <= 0;
            m_scan  <= 0;
            m_dig   <= 0;
            m_cnt   <= 16'h0000;
            m_rc    <= 1'b0;
            m_an    <= 4'b1110;
            m_seg   <= GLYPH[0];
        end else if (m_valid) begin
            m_tick <= (m_tick == TICK_DIV - 1) ? 0 : m_tick + 1;
            m_rc   <= 1'b0;
            if (load) begin
                m_cnt <= bcd ? int2bcd(bcd2int(load_val)) : load_val;
            end else if (m_tick == TICK_DIV - 1 && en) begin
                m_cnt <= step_val(m_cnt, dir, bcd);
                m_rc  <= step_wrap(m_cnt, dir, bcd);
            end
            if (m_scan == SCAN_DIV - 1) begin
                m_scan <= 0;
                m_dig  <= (m_dig + 1) % DIGITS;
            end else begin
                m_scan <= m_scan + 1;
            end
            m_an  <= exp_an(m_dig, m_cnt, blank_lz);
            m_seg <= exp_seg(m_dig, m_cnt, blank_lz);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_cnt", cnt, m_cnt);
            chk("model_Rc", Rc, m_rc);
            chk("model_AN", AN, m_an);
            chk("model_segment", segment, m_seg);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_val = v;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic wait_change(input string nm);
        logic [15:0] old;
        bit done;
        old = cnt;
        done = 0;
        for (int k = 0; k < 12 && !done; k++) begin
            cyc(1);
            if (cnt !== old) done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s: cnt stayed %h past the cycle budget", nm, old);
        end
    endtask

    logic [3:0] scan_an  [8] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111,
                                 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] scan_seg [8] = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111,
                                 7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000};

    initial begin
        // Reset, then count, then reset again mid-count.
        cyc(3);
        rst = 1'b0;
        en = 1'b1;
        dir = 1'b1;
        cyc(10);
        chk("t1_pre_reset_cnt", cnt, 16'h0002);
        rst = 1'b1;
        cyc(2);
        chk("t1_rst_cnt", cnt, 16'h0000);
        chk("t1_rst_Rc", Rc, 1'b0);
        chk("t1_rst_AN", AN, 4'b1110);
        chk("t1_rst_segment", segment, 7'b1000000);
        rst = 1'b0;
        cyc(3);
        chk("t1_no_tick_yet", cnt, 16'h0000);
        cyc(1);
        chk("t1_first_tick", cnt, 16'h0001);

        // Binary up wrap.
        bcd = 1'b0;
        do_load(16'hFFFE);
        chk("t2_load", cnt, 16'hFFFE);
        wait_change("t2_step1");
        chk("t2_cnt_ffff", cnt, 16'hFFFF);
        chk("t2_rc_low", Rc, 1'b0);
        wait_change("t2_step2");
        chk("t2_cnt_wrap", cnt, 16'h0000);
        chk("t2_rc_pulse", Rc, 1'b1);
        cyc(1);
        chk("t2_rc_one_cycle", Rc, 1'b0);

        // BCD carry, wrap and load clamp.
        bcd = 1'b1;
        do_load(16'h0099);
        wait_change("t3_carry");
        chk("t3_carry_cnt", cnt, 16'h0100);
        chk("t3_carry_rc", Rc, 1'b0);
        do_load(16'h9999);
        wait_change("t3_wrap");
        chk("t3_wrap_cnt", cnt, 16'h0000);
        chk("t3_wrap_rc", Rc, 1'b1);
        do_load(16'h00AF);
        chk("t3_load_clamp", cnt, 16'h0099);

        // Down wraps in both modes, then enable off.
        dir = 1'b0;
        do_load(16'h0000);
        wait_change("t4_bcd_down");
        chk("t4_bcd_down_cnt", cnt, 16'h9999);
        chk("t4_bcd_down_rc", Rc, 1'b1);
        bcd = 1'b0;
        do_load(16'h0000);
        wait_change("t4_bin_down");
        chk("t4_bin_down_cnt", cnt, 16'hFFFF);
        chk("t4_bin_down_rc", Rc, 1'b1);
        en = 1'b0;
        cyc(12);
        chk("t4_en_off_hold", cnt, 16'hFFFF);

        // Load coinciding with a tick beats the count step.
        en = 1'b1;
        dir = 1'b1;
        for (int k = 0; k < 8 && m_tick != TICK_DIV - 1; k++) cyc(1);
        load = 1'b1;
        load_val = 16'h1234;
        cyc(1);
        chk("t5_load_on_tick", cnt, 16'h1234);
        chk("t5_load_rc", Rc, 1'b0);
        cyc(4);
        chk("t5_load_held", cnt, 16'h1234);
        load = 1'b0;

        // Scan sequence with and without leading-zero blanking.
        rst = 1'b1;
        en = 1'b0;
        blank_lz = 1'b1;
        cyc(1);
        rst = 1'b0;
        do_load(16'h0050);
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t6_AN_%0d", i), AN, scan_an[i]);
            chk($sformatf("t6_segment_%0d", i), segment, scan_seg[i]);
            if (i == 3) blank_lz = 1'b0;
            cyc(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
